iob_eth_axi_mem_responder: RTL and testbench

// AXI4 slave memory answering the iob_eth DMA's AXI master: the far end of the DMA's AXI port.
// - Accepts INCR write bursts (RX frames and descriptors going out) into a local word RAM.
// - Serves INCR read bursts (TX frames coming in) from the same RAM.
// - Used as the system-side memory in core-level simulation and in FPGA loopback builds.
// - Independent write and read FSMs; one outstanding transaction per direction.

---
 rtl/iob_eth_axi_pkg.sv | 15 +
 rtl/iob_ram_tdp_be.sv | 31 +++
 rtl/iob_eth_axi_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_iob_eth_axi_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_axi_pkg.sv
// Shared AXI constants and FSM state encodings for the iob_eth AXI memory responder.
package iob_eth_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob_ram_tdp_be.sv
// True dual-port word RAM with per-byte write enables and registered, enable-held outputs.
module iob_ram_tdp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                a_en_i,
  input  logic [DATA_W/8-1:0] a_we_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_d_i,
  output logic [DATA_W-1:0]   a_d_o,
  input  logic                b_en_i,
  input  logic [DATA_W/8-1:0] b_we_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_d_i,
  output logic [DATA_W-1:0]   b_d_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Read-first on both ports: a read colliding with a write sees the old word.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (a_en_i && a_we_i[i]) mem[a_addr_i][i*8 +: 8] <= a_d_i[i*8 +: 8];
      if (b_en_i && b_we_i[i]) mem[b_addr_i][i*8 +: 8] <= b_d_i[i*8 +: 8];
    end
    if (a_en_i) a_d_o <= mem[a_addr_i];
    if (b_en_i) b_d_o <= mem[b_addr_i];
  end

endmodule

// File: rtl/iob_eth_axi_mem_responder.sv
// AXI4 slave word memory serving the iob_eth DMA master; independent write and read FSMs.
//   state   | meaning
//   W_IDLE  | awready high, waiting for a write address
//   W_DATA  | wready high, writing beats into RAM port A
//   W_RESP  | bvalid high, waiting for bready
//   R_IDLE  | arready high, waiting for a read address
//   R_FETCH | first word read issued on RAM port B
//   R_DATA  | rvalid high, next word fetched on each non-last handshake
module iob_eth_axi_mem_responder
  import iob_eth_axi_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic [1:0]              axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic [1:0]              axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  w_state_t                w_state;
  logic [AXI_ID_W-1:0]     w_id;
  logic [MEM_ADDR_W-1:0]   w_addr;
  logic [AXI_LEN_W-1:0]    w_len, w_cnt;
  logic                    w_err;
  r_state_t                r_state;
  logic [AXI_ID_W-1:0]     r_id;
  logic [MEM_ADDR_W-1:0]   r_addr;
  logic [AXI_LEN_W-1:0]    r_len, r_cnt;
  logic                    r_err;

  logic                    w_fire, w_end, w_beat_err, r_fire;
  logic                    ram_a_en, ram_b_en;
  logic [AXI_DATA_W/8-1:0] ram_a_we;
  logic [AXI_DATA_W-1:0]   unused_a_dout;
  logic                    unused_inputs;

  assign w_fire     = axi_wready_o & axi_wvalid_i;
  assign w_end      = axi_wlast_i | (w_cnt == w_len);
  assign w_beat_err = w_err | (axi_wlast_i != (w_cnt == w_len));
  assign r_fire     = axi_rvalid_o & axi_rready_i;

  assign ram_a_en = cke_i & ~rst_i & w_fire;
  assign ram_a_we = w_err ? '0 : axi_wstrb_i;
  assign ram_b_en = cke_i & ~rst_i & ((r_state == R_FETCH) | (r_fire & ~axi_rlast_o));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state       <= W_IDLE;
      axi_awready_o <= 1'b1;
      axi_wready_o  <= 1'b0;
      axi_bvalid_o  <= 1'b0;
      axi_bresp_o   <= AXI_RESP_OKAY;
      axi_bid_o     <= '0;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else if (cke_i) begin
      case (w_state)
        W_IDLE: if (axi_awvalid_i) begin
          w_id          <= axi_awid_i;
          w_addr        <= axi_awaddr_i[MEM_ADDR_W+1:2];
          w_len         <= axi_awlen_i;
          w_cnt         <= '0;
          w_err         <= (axi_awburst_i != AXI_BURST_INCR);
          axi_awready_o <= 1'b0;
          axi_wready_o  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (axi_wvalid_i) begin
          w_addr <= w_addr + MEM_ADDR_W'(1);
          w_cnt  <= w_cnt + AXI_LEN_W'(1);
          w_err  <= w_beat_err;
          if (w_end) begin
            axi_wready_o <= 1'b0;
            axi_bvalid_o <= 1'b1;
            axi_bresp_o  <= resp_of(w_beat_err);
            axi_bid_o    <= w_id;
            w_state      <= W_RESP;
          end
        end
        W_RESP: if (axi_bready_i) begin
          axi_bvalid_o  <= 1'b0;
          axi_awready_o <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= R_IDLE;
      axi_arready_o <= 1'b1;
      axi_rvalid_o  <= 1'b0;
      axi_rlast_o   <= 1'b0;
      axi_rresp_o   <= AXI_RESP_OKAY;
      axi_rid_o     <= '0;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        R_IDLE: if (axi_arvalid_i) begin
          r_id          <= axi_arid_i;
          r_addr        <= axi_araddr_i[MEM_ADDR_W+1:2];
          r_len         <= axi_arlen_i;
          r_cnt         <= '0;
          r_err         <= (axi_arburst_i != AXI_BURST_INCR);
          axi_arready_o <= 1'b0;
          r_state       <= R_FETCH;
        end
        R_FETCH: begin
          r_addr       <= r_addr + MEM_ADDR_W'(1);
          axi_rvalid_o <= 1'b1;
          axi_rlast_o  <= (r_len == '0);
          axi_rresp_o  <= resp_of(r_err);
          axi_rid_o    <= r_id;
          r_state      <= R_DATA;
        end
        R_DATA: if (axi_rready_i) begin
          if (axi_rlast_o) begin
            axi_rvalid_o  <= 1'b0;
            axi_rlast_o   <= 1'b0;
            axi_arready_o <= 1'b1;
            r_state       <= R_IDLE;
          end else begin
            r_addr      <= r_addr + MEM_ADDR_W'(1);
            r_cnt       <= r_cnt + AXI_LEN_W'(1);
            axi_rlast_o <= ((r_cnt + AXI_LEN_W'(1)) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  iob_ram_tdp_be #(
    .DATA_W(AXI_DATA_W),
    .ADDR_W(MEM_ADDR_W)
  ) ram (
    .clk_i   (clk_i),
    .a_en_i  (ram_a_en),
    .a_we_i  (ram_a_we),
    .a_addr_i(w_addr),
    .a_d_i   (axi_wdata_i),
    .a_d_o   (unused_a_dout),
    .b_en_i  (ram_b_en),
    .b_we_i  ('0),
    .b_addr_i(r_addr),
    .b_d_i   ('0),
    .b_d_o   (axi_rdata_o)
  );

  // Size, sideband fields and out-of-range address bits do not affect behaviour.
  assign unused_inputs = ^{axi_awaddr_i[AXI_ADDR_W-1:MEM_ADDR_W+2], axi_awaddr_i[1:0],
                           axi_araddr_i[AXI_ADDR_W-1:MEM_ADDR_W+2], axi_araddr_i[1:0],
                           axi_awsize_i, axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i,
                           axi_arsize_i, axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i,
                           unused_a_dout};

endmodule

// File: tb/tb_iob_eth_axi_mem_responder.sv
// Bench for iob_eth_axi_mem_responder: vector table plus burst, error, backpressure and reset sequences.
module tb_iob_eth_axi_mem_responder;

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, INCR = 2'b01;

  logic        clk_i = 1'b0, cke_i = 1'b1, rst_i = 1'b1;
  logic        axi_awid_i = 1'b0, axi_awvalid_i = 1'b0, axi_awready_o;
  logic [23:0] axi_awaddr_i = '0;
  logic [7:0]  axi_awlen_i = '0;
  logic [1:0]  axi_awburst_i = INCR;
  logic [31:0] axi_wdata_i = '0;
  logic [3:0]  axi_wstrb_i = '0;
  logic        axi_wlast_i = 1'b0, axi_wvalid_i = 1'b0, axi_wready_o;
  logic        axi_bid_o, axi_bvalid_o, axi_bready_i = 1'b1;
  logic [1:0]  axi_bresp_o;
  logic        axi_arid_i = 1'b0, axi_arvalid_i = 1'b0, axi_arready_o;
  logic [23:0] axi_araddr_i = '0;
  logic [7:0]  axi_arlen_i = '0;
  logic [1:0]  axi_arburst_i = INCR;
  logic        axi_rid_o, axi_rlast_o, axi_rvalid_o, axi_rready_i = 1'b1;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;

  iob_eth_axi_mem_responder dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i),
    .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
    .axi_awsize_i(3'd2), .axi_awburst_i(axi_awburst_i), .axi_awlock_i(2'd0),
    .axi_awcache_i(4'd0), .axi_awprot_i(3'd0), .axi_awqos_i(4'd0),
    .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
    .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
    .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
    .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
    .axi_bready_i(axi_bready_i),
    .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
    .axi_arsize_i(3'd2), .axi_arburst_i(axi_arburst_i), .axi_arlock_i(2'd0),
    .axi_arcache_i(4'd0), .axi_arprot_i(3'd0), .axi_arqos_i(4'd0),
    .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
    .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
    .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] data; logic last; logic [1:0] resp; logic id; } rexp_t;
  typedef struct { logic [1:0] resp; logic id; } bexp_t;
  typedef struct {
    logic [23:0] wa, ra; logic [31:0] pre, wd; logic [3:0] ws;
    logic [1:0] wb, rb; logic id; logic [31:0] exp; logic [1:0] eb, er;
  } vec_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int    r_cycles[$];
  int    tests = 0, fails = 0, cyc = 0, r_beats = 0, rv_rise = 0, bv_rise = 0;
  logic  rv_q = 1'b0, bv_q = 1'b0;
  vec_t  vt[8];

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected beats are queued by the stimulus and consumed here.
  always @(negedge clk_i) begin
    if (axi_rvalid_o && !rv_q) rv_rise = cyc;
    rv_q = axi_rvalid_o;
    if (axi_bvalid_o && !bv_q) bv_rise = cyc;
    bv_q = axi_bvalid_o;
    if (axi_rvalid_o) begin
      if (rq.size() == 0) begin
        if (axi_rready_i) begin
          tests++; fails++;
          $display("FAIL r_unexpected: beat rdata=%h arrived, none expected", axi_rdata_o);
        end
      end else begin
        chk("r_data", axi_rdata_o, rq[0].data);
        chk("r_last", {31'd0, axi_rlast_o}, {31'd0, rq[0].last});
        chk("r_resp", {30'd0, axi_rresp_o}, {30'd0, rq[0].resp});
        chk("r_id", {31'd0, axi_rid_o}, {31'd0, rq[0].id});
        if (axi_rready_i) begin
          void'(rq.pop_front());
          r_beats++;
          r_cycles.push_back(cyc);
        end
      end
    end
    if (axi_bvalid_o && axi_bready_i) begin
      if (bq.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: bresp=%b arrived, none expected", axi_bresp_o);
      end else begin
        chk("b_resp", {30'd0, axi_bresp_o}, {30'd0, bq[0].resp});
        chk("b_id", {31'd0, axi_bid_o}, {31'd0, bq[0].id});
        void'(bq.pop_front());
      end
    end
  end

  function automatic logic ready_of(input int ch);
    case (ch)
      0: return axi_awready_o;
      1: return axi_wready_o;
      default: return axi_arready_o;
    endcase
  endfunction

  task automatic hs(input int ch, output int c);
    bit ok = 0;
    c = cyc;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk_i);
      if (ready_of(ch)) begin ok = 1; c = cyc; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: channel %0d ready=0 expected 1", ch);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic aw_send(input logic id, input logic [23:0] a, input logic [7:0] len, input logic [1:0] b);
    int c;
    axi_awid_i = id; axi_awaddr_i = a; axi_awlen_i = len; axi_awburst_i = b; axi_awvalid_i = 1'b1;
    hs(0, c);
    axi_awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic last, output int c);
    axi_wdata_i = d; axi_wstrb_i = s; axi_wlast_i = last; axi_wvalid_i = 1'b1;
    hs(1, c);
    axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [23:0] a, input logic [7:0] len, input logic [1:0] b, output int c);
    axi_arid_i = id; axi_araddr_i = a; axi_arlen_i = len; axi_arburst_i = b; axi_arvalid_i = 1'b1;
    hs(2, c);
    axi_arvalid_i = 1'b0;
  endtask

  // mode 1 drives rready with the repeating pattern 1,0,0.
  task automatic wait_drain(input int mode);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (rq.size() == 0 && bq.size() == 0) done = 1;
      else begin
        axi_rready_i = (mode == 1) ? (k % 3 == 0) : 1'b1;
        @(posedge clk_i); #1;
      end
    end
    axi_rready_i = 1'b1;
    if (!done) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d R and %0d B responses outstanding, expected 0", rq.size(), bq.size());
      rq.delete(); bq.delete();
    end
  endtask

  task automatic wr_single(input logic id, input logic [23:0] a, input logic [1:0] b,
                           input logic [31:0] d, input logic [3:0] s, input logic [1:0] eb);
    int wc;
    bq.push_back('{eb, id});
    aw_send(id, a, 8'd0, b);
    w_send(d, s, 1'b1, wc);
    wait_drain(0);
    chk("b_latency", bv_rise - wc, 1);
  endtask

  task automatic wr_burst(input logic [23:0] a, input int len, input logic [31:0] base);
    int wc;
    bq.push_back('{OK, 1'b0});
    aw_send(1'b0, a, len[7:0], INCR);
    for (int i = 0; i <= len; i++) w_send(base + i, 4'hF, i == len, wc);
    wait_drain(0);
  endtask

  task automatic rd(input logic id, input logic [23:0] a, input int len, input logic [1:0] b, input int mode);
    int arc;
    ar_send(id, a, len[7:0], b, arc);
    wait_drain(mode);
    chk("r_latency", rv_rise - arc, 2);
  endtask

  task automatic push_r(input logic [31:0] base, input int len, input logic [1:0] resp, input logic id);
    for (int i = 0; i <= len; i++) rq.push_back('{base + i, i == len, resp, id});
  endtask

  initial begin
    int wc, base;
    bit ok;
    vt[0] = '{24'h000010, 24'h000010, 32'h11111111, 32'hDEADBEEF, 4'hF, INCR, INCR, 1'b0, 32'hDEADBEEF, OK, OK};
    vt[1] = '{24'h000020, 24'h000020, 32'h11223344, 32'hAAAABBBB, 4'h3, INCR, INCR, 1'b1, 32'h1122BBBB, OK, OK};
    vt[2] = '{24'h000024, 24'h000024, 32'h11223344, 32'hAAAABBBB, 4'hC, INCR, INCR, 1'b0, 32'hAAAA3344, OK, OK};
    vt[3] = '{24'h000028, 24'h000028, 32'h55667788, 32'hFFFFFFFF, 4'h0, INCR, INCR, 1'b1, 32'h55667788, OK, OK};
    vt[4] = '{24'h00002C, 24'h00002C, 32'h01020304, 32'hA0B0C0D0, 4'h5, INCR, INCR, 1'b0, 32'h01B003D0, OK, OK};
    vt[5] = '{24'h004030, 24'h000030, 32'h12345678, 32'hCAFEF00D, 4'hF, INCR, INCR, 1'b1, 32'hCAFEF00D, OK, OK};
    vt[6] = '{24'h000050, 24'h000050, 32'h0BADF00D, 32'h99999999, 4'hF, 2'b00, INCR, 1'b1, 32'h0BADF00D, SLV, OK};
    vt[7] = '{24'h000054, 24'h000054, 32'h600DCAFE, 32'h12121212, 4'hF, INCR, 2'b10, 1'b0, 32'h12121212, OK, SLV};

    @(posedge clk_i); @(negedge clk_i);
    chk("rst_awready", {31'd0, axi_awready_o}, 1);
    chk("rst_arready", {31'd0, axi_arready_o}, 1);
    chk("rst_wready", {31'd0, axi_wready_o}, 0);
    chk("rst_bvalid_rvalid_rlast", {29'd0, axi_bvalid_o, axi_rvalid_o, axi_rlast_o}, 0);
    chk("rst_resp_id", {26'd0, axi_bresp_o, axi_rresp_o, axi_bid_o, axi_rid_o}, 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    foreach (vt[i]) begin
      wr_single(vt[i].id, vt[i].wa, INCR, vt[i].pre, 4'hF, OK);
      wr_single(vt[i].id, vt[i].wa, vt[i].wb, vt[i].wd, vt[i].ws, vt[i].eb);
      rq.push_back('{vt[i].exp, 1'b1, vt[i].er, vt[i].id});
      rd(vt[i].id, vt[i].ra, 0, vt[i].rb, 0);
    end

    // Burst of four with rready held high: one beat per cycle.
    wr_burst(24'h000100, 3, 32'd1);
    r_cycles.delete();
    push_r(32'd1, 3, OK, 1'b0);
    rd(1'b0, 24'h000100, 3, INCR, 0);
    chk("burst_beats", r_cycles.size(), 4);
    for (int i = 1; i < r_cycles.size(); i++) chk("burst_back_to_back", r_cycles[i] - r_cycles[i-1], 1);

    // Burst that crosses the top of the RAM wraps to word 0.
    wr_burst(24'h003FFC, 1, 32'h77000000);
    push_r(32'h77000001, 0, OK, 1'b0);
    rd(1'b0, 24'h000000, 0, INCR, 0);
    push_r(32'h77000000, 1, OK, 1'b1);
    rd(1'b1, 24'h003FFC, 1, INCR, 0);

    // Early wlast on beat 2 of a len-3 burst.
    bq.push_back('{SLV, 1'b1});
    aw_send(1'b1, 24'h000400, 8'd3, INCR);
    w_send(32'hA, 4'hF, 1'b0, wc);
    w_send(32'hB, 4'hF, 1'b0, wc);
    w_send(32'hC, 4'hF, 1'b1, wc);
    wait_drain(0);
    @(negedge clk_i);
    chk("early_last_wready", {31'd0, axi_wready_o}, 0);
    chk("early_last_awready", {31'd0, axi_awready_o}, 1);
    @(posedge clk_i); #1;
    wr_single(1'b0, 24'h000404, INCR, 32'h00000055, 4'hF, OK);

    // len 0 without wlast still ends the burst, with an error.
    bq.push_back('{SLV, 1'b0});
    aw_send(1'b0, 24'h000408, 8'd0, INCR);
    w_send(32'h66, 4'hF, 1'b0, wc);
    wait_drain(0);

    // Backpressure on a three-beat read.
    wr_burst(24'h000200, 2, 32'h0000C0DE);
    r_cycles.delete();
    push_r(32'h0000C0DE, 2, OK, 1'b1);
    rd(1'b1, 24'h000200, 2, INCR, 1);
    chk("bp_beats", r_cycles.size(), 3);

    // Clock enable low freezes the write FSM.
    cke_i = 1'b0;
    axi_awaddr_i = 24'h000500; axi_awlen_i = 8'd0; axi_awburst_i = INCR; axi_awvalid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("cke_wready", {31'd0, axi_wready_o}, 0);
    chk("cke_awready", {31'd0, axi_awready_o}, 1);
    axi_awvalid_i = 1'b0;
    cke_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset in the middle of a len-7 read.
    wr_burst(24'h000300, 7, 32'h300000A0);
    push_r(32'h300000A0, 7, OK, 1'b0);
    ar_send(1'b0, 24'h000300, 8'd7, INCR, wc);
    base = r_beats;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk_i); #2;
      if (r_beats - base >= 3) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rst_mid_read_timeout: %0d beats seen, expected 3", r_beats - base);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rq.delete();
    @(negedge clk_i);
    chk("rst_mid_rvalid", {31'd0, axi_rvalid_o}, 0);
    chk("rst_mid_arready", {31'd0, axi_arready_o}, 1);
    @(posedge clk_i); #1;
    push_r(32'h300000A0, 7, OK, 1'b1);
    rd(1'b1, 24'h000300, 7, INCR, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
